// File: rtl/data_request_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_request_ctrl_if
//
// Bundle of the data-request handshake between the decode/fetch side of the
// pipeline, the data request controller and the data memory port.
//
// Parameters
//   ADDR_W : width of the data address
//   DATA_W : width of the store data
//
// Signals
//   ihit        : instruction fetch completes this cycle
//   dhit        : data access completes this cycle
//   dREN/dWEN   : decoded instruction asks for a load / store
//   daddr       : load/store address
//   dstore      : store data
//   flush       : suppresses capture of a new request
//   dmemREN     : registered read request towards memory
//   dmemWEN     : registered write request towards memory
//   dmemaddr    : latched request address
//   dmemstore   : latched store data
//   pcen        : PC advance enable
//   busy        : a memory request is outstanding
//   timeout_err : sticky flag, a request was abandoned after waiting too long
//
// Modports
//   slave  : the controller itself
//   master : the pipeline / memory side that drives the controller
// ---------------------------------------------------------------------------
interface data_request_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              ihit;
  logic              dhit;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              flush;

  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              pcen;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  ihit, dhit, dREN, dWEN, daddr, dstore, flush,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, pcen, busy, timeout_err
  );

  modport master (
    output ihit, dhit, dREN, dWEN, daddr, dstore, flush,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, pcen, busy, timeout_err
  );

endinterface

// File: rtl/data_request_ctrl.sv
// ---------------------------------------------------------------------------
// data_request_ctrl
//
// Turns a decoded load/store into a single registered memory request and
// holds it until the memory answers with dhit. While the request is
// outstanding the PC is frozen (pcen low) and busy is high. An optional
// wait limit abandons a request that never completes, raising a sticky
// timeout_err flag so the condition is visible to software/debug.
//
// Parameters
//   ADDR_W  : width of the data address
//   DATA_W  : width of the store data
//   TIMEOUT : maximum number of waiting cycles without dhit; 0 = wait forever
//
// Ports
//   CLK  : clock, all state changes on the rising edge
//   nRST : asynchronous, active-low reset
//   bus  : data_request_ctrl_if.slave, request inputs and memory-side outputs
// ---------------------------------------------------------------------------
module data_request_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               nRST,
  data_request_ctrl_if.slave bus
);

  // Wait counter only needs to reach TIMEOUT; keep at least one bit so the
  // declaration stays legal when the timeout is disabled.
  localparam int              CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
  localparam logic            TMO_EN  = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              ren_q;
  logic              wen_q;
  logic              busy_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;

  logic              any_req;
  logic              capture;
  logic              expire;

  assign any_req = bus.dREN | bus.dWEN;

  // A new request is taken only when the fetch of the instruction that
  // carries it completes, and never on a flushed cycle.
  assign capture = (state == IDLE) & bus.ihit & any_req & ~bus.flush;

  // dhit has priority: a completion in the last allowed cycle is a normal
  // completion, not a timeout.
  assign expire  = TMO_EN & (state == PEND) & ~bus.dhit & (wait_cnt == TMO_LIM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // dhit is deliberately ignored here; address/data keep their last
          // latched values.
          if (capture) begin
            state    <= PEND;
            busy_q   <= 1'b1;
            addr_q   <= bus.daddr;
            store_q  <= bus.dstore;
            // Store wins when both enables are set.
            ren_q    <= bus.dREN & ~bus.dWEN;
            wen_q    <= bus.dWEN;
            wait_cnt <= '0;
          end
        end

        PEND: begin
          // ihit and flush are ignored: the outstanding access must finish.
          if (bus.dhit) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ren_q  <= 1'b0;
            wen_q  <= 1'b0;
          end else if (expire) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ren_q  <= 1'b0;
            wen_q  <= 1'b0;
            err_q  <= 1'b1;
          end else if (TMO_EN) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          ren_q  <= 1'b0;
          wen_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dmemREN     = ren_q;
  assign bus.dmemWEN     = wen_q;
  assign bus.dmemaddr    = addr_q;
  assign bus.dmemstore   = store_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;

  // PC may advance when a fetch completes with no data access to start (or
  // the access is flushed), or when the outstanding data access completes.
  assign bus.pcen = ((state == IDLE) & bus.ihit & (~any_req | bus.flush))
                  | ((state == PEND) & bus.dhit);

endmodule

// File: tb/tb_data_request_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_request_ctrl
//
// Directed scenarios followed by a randomized run, every cycle compared
// against a transaction-level reference model of the request controller.
// ---------------------------------------------------------------------------
module tb_data_request_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  data_request_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_request_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: is a request outstanding, what was captured, how many
  // cycles it has waited without an answer, and whether any request expired.
  bit          m_busy;
  bit          m_ren;
  bit          m_wen;
  bit          m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_store;
  int          m_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_ren   = 0;
    m_wen   = 0;
    m_err   = 0;
    m_addr  = '0;
    m_store = '0;
    m_wait  = 0;
  endtask

  function automatic bit model_pcen();
    if (!m_busy) return bus.ihit && (!(bus.dREN || bus.dWEN) || bus.flush);
    return bus.dhit;
  endfunction

  task automatic model_edge();
    if (!m_busy) begin
      if (bus.ihit && (bus.dREN || bus.dWEN) && !bus.flush) begin
        m_busy  = 1;
        m_addr  = bus.daddr;
        m_store = bus.dstore;
        m_wen   = bus.dWEN;
        m_ren   = bus.dREN && !bus.dWEN;
        m_wait  = 0;
      end
    end else if (bus.dhit) begin
      m_busy = 0; m_ren = 0; m_wen = 0;
    end else if (m_wait == TMO) begin
      m_busy = 0; m_ren = 0; m_wen = 0; m_err = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".dmemREN"},     bus.dmemREN,     m_ren);
    chk({tag, ".dmemWEN"},     bus.dmemWEN,     m_wen);
    chk({tag, ".busy"},        bus.busy,        m_busy);
    chk({tag, ".timeout_err"}, bus.timeout_err, m_err);
    chk({tag, ".dmemaddr"},    bus.dmemaddr,    m_addr);
    chk({tag, ".dmemstore"},   bus.dmemstore,   m_store);
  endtask

  task automatic set_in(input bit ih, input bit dh, input bit rd, input bit wr,
                        input bit fl, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ihit   = ih;
    bus.dhit   = dh;
    bus.dREN   = rd;
    bus.dWEN   = wr;
    bus.flush  = fl;
    bus.daddr  = a;
    bus.dstore = d;
  endtask

  // Inputs are changed only just after a rising edge; pcen is checked at the
  // falling edge, registered outputs just after the next rising edge.
  task automatic step(input string tag);
    @(negedge CLK);
    chk({tag, ".pcen"}, bus.pcen, model_pcen());
    @(posedge CLK);
    model_edge();
    #1;
    check_regs(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    set_in(0, 0, 0, 0, 0, '0, '0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_regs("reset");
    chk("reset.pcen", bus.pcen, 1'b0);
    nRST = 1'b1;

    // Load: held for three cycles, completed by dhit on the third
    set_in(1, 0, 1, 0, 0, 32'h100, 32'h0);
    step("load.cap");
    chk("load.addr", bus.dmemaddr, 32'h100);
    chk("load.ren",  bus.dmemREN,  1'b1);
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("load.w1");
    step("load.w2");
    bus.dhit = 1;
    step("load.hit");
    bus.dhit = 0;
    step("load.after");
    chk("load.ren_off", bus.dmemREN, 1'b0);

    // Store with both enables: write wins; PEND ignores new input traffic
    set_in(1, 0, 1, 1, 0, 32'h40, 32'hDEADBEEF);
    step("store.cap");
    chk("store.wen",  bus.dmemWEN,   1'b1);
    chk("store.ren",  bus.dmemREN,   1'b0);
    chk("store.data", bus.dmemstore, 32'hDEADBEEF);
    set_in(1, 0, 1, 0, 1, 32'h999, 32'h12345678);
    step("store.w1");
    step("store.w2");
    bus.dhit = 1;
    step("store.hit");
    set_in(0, 0, 0, 0, 0, '0, '0);
    step("store.after");

    // Flushed request and a spurious dhit in IDLE
    set_in(1, 0, 1, 0, 1, 32'h500, 32'h0);
    @(negedge CLK);
    chk("flush.pcen_direct", bus.pcen, 1'b1);
    step("flush");
    chk("flush.busy", bus.busy, 1'b0);
    set_in(0, 1, 0, 0, 0, 32'h77, 32'h77);
    step("spurious");
    chk("spurious.addr", bus.dmemaddr, 32'h40);

    // Boundary: dhit arrives exactly when the wait limit is reached
    set_in(1, 0, 1, 0, 0, 32'h200, 32'h0);
    step("bnd.cap");
    set_in(0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < TMO; i++) step("bnd.wait");
    bus.dhit = 1;
    step("bnd.hit");
    chk("bnd.err", bus.timeout_err, 1'b0);
    bus.dhit = 0;

    // Timeout: no dhit ever arrives
    set_in(1, 0, 1, 0, 0, 32'h300, 32'h0);
    step("tmo.cap");
    set_in(0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < TMO; i++) step("tmo.wait");
    chk("tmo.busy_before", bus.busy, 1'b1);
    step("tmo.expire");
    chk("tmo.err",  bus.timeout_err, 1'b1);
    chk("tmo.busy", bus.busy,        1'b0);
    chk("tmo.ren",  bus.dmemREN,     1'b0);
    set_in(1, 0, 1, 0, 0, 32'h304, 32'h0);
    step("tmo.next");
    set_in(0, 1, 0, 0, 0, '0, '0);
    step("tmo.next_hit");
    chk("tmo.err_sticky", bus.timeout_err, 1'b1);

    // Reset between clock edges while a request is outstanding
    set_in(1, 0, 0, 1, 0, 32'h600, 32'hCAFE);
    step("rst.cap");
    set_in(0, 0, 0, 0, 0, '0, '0);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    chk("rst.ren_async",  bus.dmemREN, 1'b0);
    chk("rst.wen_async",  bus.dmemWEN, 1'b0);
    chk("rst.busy_async", bus.busy,    1'b0);
    check_regs("rst.async");
    @(negedge CLK);
    #1;
    nRST = 1'b1;
    step("rst.rel1");
    step("rst.rel2");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 4) == 0,
             $urandom, $urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
